// File: rtl/mac_lookup_pkg.sv
// Shared types and constants for the MAC lookup arbiter: FSM encoding,
// latched table response, and address widths.
package mac_lookup_pkg;

    localparam int MAC_W = 48;
    localparam int IP_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_e;

    typedef struct packed {
        logic             hit;
        logic [MAC_W-1:0] mac;
    } lkp_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: the first asserted request at or after ptr
// (wrapping) wins; gnt is one-hot (or zero) and idx is its position.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    int j;

    // Scan from the farthest position back toward ptr so the closest hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j[IW-1:0]]) begin
                gnt              = '0;
                gnt[j[IW-1:0]]   = 1'b1;
                idx              = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Arbitrates NUM_REQ requesters onto one ARP/MAC table port, one lookup in
// flight. Define MAC_LOOKUP_TIMEOUT_EN to abandon lookups after TIMEOUT_CYCLES.
module mac_lookup_arbiter
    import mac_lookup_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IP_W-1:0] req_ip,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    lkp_req_valid,
    output logic [IP_W-1:0]         lkp_req_ip,
    input  logic                    lkp_req_ready,
    input  logic                    lkp_rsp_valid,
    input  logic                    lkp_rsp_hit,
    input  logic [MAC_W-1:0]        lkp_rsp_mac,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    rsp_hit,
    output logic [MAC_W-1:0]        rsp_mac,
    output logic                    busy,
    output logic                    timeout_err,
    output state_e                  dbg_state
);

    localparam int IDXW = $clog2(NUM_REQ);

    // Handshakes: a transfer happens on a clock edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.
    state_e          state, state_nxt;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] grant;
    logic [IP_W-1:0] cap_ip;
    lkp_rsp_t        rsp_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDXW-1:0]    arb_idx;
    logic               tmo_hit;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef MAC_LOOKUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt;

    // Held at zero outside WAIT, so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clock) begin
        if (reset || state != ST_WAIT) tmo_cnt <= '0;
        else                           tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit     = (state == ST_WAIT) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_hit && !lkp_rsp_valid;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            cap_ip <= '0;
            rsp_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (|req_valid) begin
                    grant  <= arb_idx;
                    cap_ip <= req_ip[arb_idx*IP_W +: IP_W];
                end
                ST_WAIT: if (lkp_rsp_valid) begin
                    rsp_q.hit <= lkp_rsp_hit;
                    rsp_q.mac <= lkp_rsp_hit ? lkp_rsp_mac : '0;
                end else if (tmo_hit) begin
                    rsp_q <= '0;
                end
                ST_DELIVER: if (rsp_ready[grant]) begin
                    rr_ptr <= (grant == IDXW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        lkp_req_valid = 1'b0;
        lkp_req_ip    = '0;
        rsp_valid     = '0;
        rsp_hit       = 1'b0;
        rsp_mac       = '0;
        case (state)
            ST_IDLE: begin
                req_ready = arb_gnt;
                if (|req_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                lkp_req_valid = 1'b1;
                lkp_req_ip    = cap_ip;
                if (lkp_req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (lkp_rsp_valid || tmo_hit) state_nxt = ST_DELIVER;
            end
            ST_DELIVER: begin
                rsp_valid[grant] = 1'b1;
                rsp_hit          = rsp_q.hit;
                rsp_mac          = rsp_q.mac;
                if (rsp_ready[grant]) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Directed bench for mac_lookup_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16);
// timeout cases follow the MAC_LOOKUP_TIMEOUT_EN build setting.
module tb_mac_lookup_arbiter;
    import mac_lookup_pkg::*;

    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_ip;
    logic [N-1:0]    req_ready;
    logic            lkp_req_valid;
    logic [31:0]     lkp_req_ip;
    logic            lkp_req_ready;
    logic            lkp_rsp_valid;
    logic            lkp_rsp_hit;
    logic [47:0]     lkp_rsp_mac;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic            rsp_hit;
    logic [47:0]     rsp_mac;
    logic            busy;
    logic            timeout_err;
    state_e          dbg_state;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q[$];
    logic [31:0]  ips[N];

    mac_lookup_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ip(req_ip), .req_ready(req_ready),
        .lkp_req_valid(lkp_req_valid), .lkp_req_ip(lkp_req_ip), .lkp_req_ready(lkp_req_ready),
        .lkp_rsp_valid(lkp_rsp_valid), .lkp_rsp_hit(lkp_rsp_hit), .lkp_rsp_mac(lkp_rsp_mac),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_mac(rsp_mac),
        .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        #1;
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_lkp_req_valid"}, 64'(lkp_req_valid), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_mac"}, 64'(rsp_mac), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    endtask

    // Present valid in IDLE, compare the granted one-hot with the queue head.
    task automatic accept(input logic [N-1:0] valid, output int g);
        logic [N-1:0] exp;
        int n;
        n = 0;
        req_valid = valid;
        #1;
        while (req_ready == '0 && n < 20) begin
            step();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("grant", 64'(req_ready), 64'(exp));
        g = 0;
        for (int i = 0; i < N; i++) if (exp[i]) g = i;
        step();
    endtask

    task automatic issue(input int rdy_wait, input int g);
        for (int c = 0; c <= rdy_wait; c++) begin
            lkp_req_ready = (c == rdy_wait);
            #1;
            check("lkp_req_valid", 64'(lkp_req_valid), 64'd1);
            check("lkp_req_ip", 64'(lkp_req_ip), 64'(ips[g]));
            check("req_ready_busy", 64'(req_ready), 64'd0);
            step();
        end
        lkp_req_ready = 1'b0;
    endtask

    task automatic respond(input logic hit, input logic [47:0] mac);
        lkp_rsp_valid = 1'b1;
        lkp_rsp_hit   = hit;
        lkp_rsp_mac   = mac;
        #1;
        check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        lkp_rsp_valid = 1'b0;
    endtask

    task automatic deliver(input int dlv_wait, input int g, input logic hit, input logic [47:0] mac);
        logic [N-1:0] own;
        own = N'(1) << g;
        for (int c = 0; c <= dlv_wait; c++) begin
            rsp_ready     = (c == dlv_wait) ? own : (~own & {N{1'b1}});
            lkp_rsp_valid = (c == 0 && dlv_wait > 0);
            lkp_rsp_hit   = ~hit;
            lkp_rsp_mac   = {16'hBAD0, $urandom};
            #1;
            check("rsp_valid", 64'(rsp_valid), 64'(own));
            check("rsp_hit", 64'(rsp_hit), 64'(hit));
            check("rsp_mac", 64'(rsp_mac), hit ? 64'(mac) : 64'd0);
            step();
        end
        rsp_ready     = '0;
        lkp_rsp_valid = 1'b0;
        #1;
        check("back_to_idle", 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic lookup(input logic [N-1:0] valid, input int rdy_wait, input logic hit,
                          input logic [47:0] mac, input int dlv_wait);
        int g;
        accept(valid, g);
        issue(rdy_wait, g);
        respond(hit, mac);
        deliver(dlv_wait, g, hit, mac);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        for (int i = 0; i < N; i++) ips[i] = 32'h0A000001 + i;
        req_ip = {ips[3], ips[2], ips[1], ips[0]};
        reset = 1'b1;
        req_valid = '0; rsp_ready = '0;
        lkp_req_ready = 1'b0; lkp_rsp_valid = 1'b0; lkp_rsp_hit = 1'b0; lkp_rsp_mac = '0;
        repeat (3) step();
        reset = 1'b0;
        check_idle_outputs("reset");

        // Fairness with every requester pending: 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) exp_q.push_back(N'(1) << (k % 4));
        for (int k = 0; k < 8; k++) lookup(4'b1111, 0, 1'b1, 48'h0000_0000_1000 + k, 0);
        req_valid = '0;

        // Single request, minimum latency, hit.
        exp_q.push_back(4'b0001);
        lookup(4'b0001, 0, 1'b1, 48'h001122334455, 0);
        req_valid = '0;

        // Pointer at 1 with requesters 0 and 3: wraps forward to 3.
        exp_q.push_back(4'b1000);
        lookup(4'b1001, 0, 1'b1, 48'hA1A2A3A4A5A6, 1);
        req_valid = '0;

        // Miss with table and requester backpressure; MAC must read as zero.
        exp_q.push_back(4'b0100);
        lookup(4'b0100, 5, 1'b0, 48'hDEADBEEFCAFE, 4);
        req_valid = '0;

`ifdef MAC_LOOKUP_TIMEOUT_EN
        // Pointer 3, requesters 0,1 -> 0. No response: pulse on the 16th WAIT cycle.
        exp_q.push_back(4'b0001);
        accept(4'b0011, g);
        issue(0, g);
        for (int c = 1; c <= 16; c++) begin
            #1;
            check("tmo_pulse", 64'(timeout_err), 64'(c == 16));
            check("tmo_busy", 64'(busy), 64'd1);
            step();
        end
        deliver(0, g, 1'b0, 48'h0);
        // Pointer 1 -> requester 1; response lands on the 16th cycle and wins.
        exp_q.push_back(4'b0010);
        accept(4'b0011, g);
        issue(0, g);
        for (int c = 1; c <= 15; c++) begin
            #1;
            check("tmo_quiet", 64'(timeout_err), 64'd0);
            step();
        end
        lkp_rsp_valid = 1'b1; lkp_rsp_hit = 1'b1; lkp_rsp_mac = 48'h0A0B0C0D0E0F;
        #1;
        check("tmo_race", 64'(timeout_err), 64'd0);
        step();
        lkp_rsp_valid = 1'b0;
        deliver(0, g, 1'b1, 48'h0A0B0C0D0E0F);
`else
        // No timeout logic: WAIT holds indefinitely until the table answers.
        exp_q.push_back(4'b0001);
        accept(4'b0011, g);
        issue(0, g);
        for (int c = 1; c <= 20; c++) begin
            #1;
            check("nowait_tmo", 64'(timeout_err), 64'd0);
            check("nowait_state", 64'(dbg_state), 64'(ST_WAIT));
            step();
        end
        respond(1'b1, 48'h0A0B0C0D0E0F);
        deliver(0, g, 1'b1, 48'h0A0B0C0D0E0F);
`endif
        req_valid = '0;

        // Reset mid-WAIT, then a stray response, then arbitration restarts at 0.
        exp_q.push_back(4'b0100);
        accept(4'b1100, g);
        issue(0, g);
        req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("mid_reset");
        lkp_rsp_valid = 1'b1; lkp_rsp_hit = 1'b1; lkp_rsp_mac = 48'hFFFFFFFFFFFF;
        step();
        lkp_rsp_valid = 1'b0;
        check_idle_outputs("stray_rsp");
        exp_q.push_back(4'b0001);
        lookup(4'b1111, 0, 1'b1, 48'h123456789ABC, 0);
        req_valid = '0;

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_lookup_arbiter.md
MAC_LOOKUP_ARBITER -- requirements
Module: mac_lookup_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the MAC lookup port (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 256: cycles to wait for a lookup response before abandoning it (must be >= 2).
REQ-003 clock  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester lookup request valid.
REQ-006 req_ip  input  NUM_REQ*32  per-requester destination IPv4 address; requester i occupies bits [32i+31:32i].
REQ-007 req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
REQ-008 lkp_req_valid  output  1  request to the shared ARP/MAC table.
REQ-009 lkp_req_ip  output  32  IP address presented to the table.
REQ-010 lkp_req_ready  input  1  table accepts the request.
REQ-011 lkp_rsp_valid  input  1  table response valid; single-cycle pulse, no backpressure.
REQ-012 lkp_rsp_hit  input  1  table holds an entry for the IP.
REQ-013 lkp_rsp_mac  input  48  resolved MAC address; meaningful only when hit=1.
REQ-014 rsp_valid  output  NUM_REQ  per-requester response valid; one-hot or zero.
REQ-015 rsp_ready  input  NUM_REQ  per-requester response accept.
REQ-016 rsp_hit  output  1  shared response hit flag.
REQ-017 rsp_mac  output  48  shared response MAC; forced to 0 when rsp_hit=0.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 timeout_err  output  1  single-cycle pulse when a lookup is abandoned.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT and DELIVER, with one lookup outstanding at most.
REQ-021 In IDLE, if any req_valid is high, the round-robin winner SHALL be chosen starting at pointer rr_ptr, req_ready[winner] SHALL be asserted combinationally, req_ip[winner] SHALL be captured, the grant index SHALL be stored, and the FSM SHALL move to ISSUE next cycle.
REQ-022 In ISSUE, lkp_req_valid SHALL be high with lkp_req_ip equal to the captured IP, held stable until lkp_req_ready; on handshake the FSM SHALL move to WAIT.
REQ-023 In WAIT, a lkp_rsp_valid pulse SHALL latch hit and MAC (MAC zeroed on miss) and move the FSM to DELIVER; lkp_rsp_valid in any other state SHALL be ignored.
REQ-024 In DELIVER, rsp_valid[grant] SHALL stay high with stable rsp_hit/rsp_mac until rsp_ready[grant]; on handshake rr_ptr SHALL become (grant+1) mod NUM_REQ and the FSM SHALL return to IDLE.
REQ-025 The minimum request-to-response latency SHALL be 3 cycles (accept, issue with immediate ready, response in the first WAIT cycle, then DELIVER).
REQ-026 rsp_ready and req_valid of non-granted requesters SHALL have no effect outside IDLE; the next arbitration SHALL happen only after DELIVER completes.

Reset
REQ-027 On reset in any state: FSM=IDLE, rr_ptr=0, grant=0, captured IP/hit/MAC=0, timeout counter=0; all outputs 0 in the following cycle; an in-flight lookup SHALL be dropped and any late response ignored.

Configuration
REQ-028 With MAC_LOOKUP_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each cycle in WAIT; if it reaches TIMEOUT_CYCLES-1 with no response, the block SHALL pulse timeout_err, latch hit=0 and MAC=0, and enter DELIVER. A response arriving in that same cycle SHALL take precedence, with no timeout_err.
REQ-029 Without MAC_LOOKUP_TIMEOUT_EN, the counter SHALL not exist, WAIT SHALL be unbounded, and timeout_err SHALL be tied to 0.

Structure
REQ-030 The state encoding, the response struct (hit, mac[47:0]) and the MAC_W=48 and IP_W=32 constants SHALL reside in shared package mac_lookup_pkg.
REQ-031 The round-robin pointer and priority logic SHALL be a sub-module rr_arbiter (parameter N; inputs req and ptr; outputs one-hot gnt and index).

Verification
REQ-032 Single request: req_valid=0001, ip=0x0A000001, table ready immediately, hit with MAC 0x001122334455 one cycle later -> rsp_valid=0001 with that MAC, response 3 cycles after accept.
REQ-033 Fairness: req_valid=1111 held constant for 8 lookups -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Miss plus backpressure: lkp_req_ready low for 5 cycles, then a miss; rsp_ready low for 4 cycles -> lkp_req_ip stable throughout, rsp_hit=0 and rsp_mac=0 held until handshake.
REQ-035 Timeout (macro on, TIMEOUT_CYCLES=16): no response -> timeout_err pulses once on the 16th WAIT cycle and requester gets hit=0; a response arriving on that same cycle instead -> hit=1 and no timeout_err.
REQ-036 Reset mid-WAIT followed by a stray lkp_rsp_valid -> all outputs 0, the stray response is ignored, and the next request goes to requester 0 first.
